// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with saturation and refractory FSM.
// Optional adaptive threshold enabled by defining ADAPTIVE_THRESHOLD_EN.
module lif_neuron #(
    parameter int WIDTH         = 18,
    parameter int LEAK_SHIFT    = 4,
    parameter int THRESHOLD     = 1000,
    parameter int V_RESET       = 0,
    parameter int REFRACT_STEPS = 4,
    parameter int THETA_INC     = 64,
    parameter int THETA_MAX     = 4095
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step,
    input  logic [WIDTH-1:0] i_syn,
    output logic             spike,
    output logic [WIDTH-1:0] v_mem,
    output logic             refractory,
    output logic [WIDTH-1:0] thr_eff
);

    typedef enum logic {
        S_INT,
        S_REF
    } state_t;

    localparam int XW = WIDTH + 2;
    localparam logic signed [XW-1:0] SAT_MAX = XW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_MIN = -XW'(2 ** (WIDTH - 1));
    localparam logic [WIDTH-1:0] VRST = WIDTH'(V_RESET);
    localparam logic [WIDTH-1:0] THR  = WIDTH'(THRESHOLD);
    localparam logic [7:0]       RSTEPS = 8'(REFRACT_STEPS);

    state_t           r_state;
    state_t           w_state_nx;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nx;
    logic [WIDTH-1:0] r_v;
    logic [WIDTH-1:0] w_v_nx;
    logic             r_spike;
    logic             w_spike_nx;

    logic signed [XW-1:0] w_vext;
    logic signed [XW-1:0] w_leak;
    logic signed [XW-1:0] w_isyn;
    logic signed [XW-1:0] w_vsum;
    logic [WIDTH-1:0]     w_vsat;
    logic [WIDTH-1:0]     w_thr;
    logic                 w_fire;

    assign w_vext = {{2{r_v[WIDTH-1]}}, r_v};
    assign w_isyn = {{2{i_syn[WIDTH-1]}}, i_syn};
    assign w_leak = w_vext >>> LEAK_SHIFT;
    assign w_vsum = w_vext - w_leak + w_isyn;

    // Clamp the widened sum back into the signed WIDTH range
    always_comb begin
        w_vsat = w_vsum[WIDTH-1:0];
        if (w_vsum > SAT_MAX) begin
            w_vsat = SAT_MAX[WIDTH-1:0];
        end else if (w_vsum < SAT_MIN) begin
            w_vsat = SAT_MIN[WIDTH-1:0];
        end
    end

    assign w_fire = $signed(w_vsat) >= $signed(w_thr);

`ifdef ADAPTIVE_THRESHOLD_EN
    localparam logic [WIDTH:0] T_INC = (WIDTH+1)'(THETA_INC);
    localparam logic [WIDTH:0] T_MAX = (WIDTH+1)'(THETA_MAX);

    logic [WIDTH-1:0] r_theta;
    logic [WIDTH-1:0] w_theta_nx;
    logic [WIDTH:0]   w_theta_sum;

    assign w_thr       = THR + r_theta;
    assign w_theta_sum = {1'b0, r_theta} + T_INC;

    // Raise theta on a firing step, otherwise let it decay by one per step
    always_comb begin
        w_theta_nx = r_theta;
        if (step) begin
            if (r_state == S_INT && w_fire) begin
                if (w_theta_sum > T_MAX) begin
                    w_theta_nx = T_MAX[WIDTH-1:0];
                end else begin
                    w_theta_nx = w_theta_sum[WIDTH-1:0];
                end
            end else if (r_theta != '0) begin
                w_theta_nx = r_theta - 1'b1;
            end
        end
    end

    // Theta register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_theta <= '0;
        end else begin
            r_theta <= w_theta_nx;
        end
    end
`else
    assign w_thr = THR;
`endif

    // Next-state, membrane and spike logic for the integrate/refract FSM
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_v_nx     = r_v;
        w_spike_nx = 1'b0;
        if (step) begin
            unique case (r_state)
                S_INT: begin
                    if (w_fire) begin
                        w_spike_nx = 1'b1;
                        w_v_nx     = VRST;
                        if (RSTEPS != 8'd0) begin
                            w_state_nx = S_REF;
                            w_cnt_nx   = RSTEPS;
                        end
                    end else begin
                        w_v_nx = w_vsat;
                    end
                end
                S_REF: begin
                    w_v_nx = VRST;
                    if (r_cnt == 8'd1) begin
                        w_state_nx = S_INT;
                        w_cnt_nx   = 8'd0;
                    end else begin
                        w_cnt_nx = r_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nx = S_INT;
                    w_cnt_nx   = 8'd0;
                end
            endcase
        end
    end

    // State, counter, potential and spike registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_INT;
            r_cnt   <= 8'd0;
            r_v     <= VRST;
            r_spike <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_v     <= w_v_nx;
            r_spike <= w_spike_nx;
        end
    end

    assign spike      = r_spike;
    assign v_mem      = r_v;
    assign refractory = (r_state == S_REF);
    assign thr_eff    = w_thr;

endmodule

// File: tb/tb_lif_neuron.sv
// Scoreboard bench for lif_neuron: driver queues expected outputs,
// a negedge monitor pops and compares one entry per issued cycle.
module tb_lif_neuron;

    typedef struct {
        logic        spk;
        logic [17:0] v;
        logic        refr;
        logic [17:0] thr;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        step;
    logic [17:0] i_syn;
    logic        spike;
    logic [17:0] v_mem;
    logic        refractory;
    logic [17:0] thr_eff;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   th = 0;
    logic issued = 1'b0;
    logic pend = 1'b0;

    localparam logic [17:0] NEG_MAX = 18'h20000;

    lif_neuron dut (
        .clock      (clock),
        .reset      (reset),
        .step       (step),
        .i_syn      (i_syn),
        .spike      (spike),
        .v_mem      (v_mem),
        .refractory (refractory),
        .thr_eff    (thr_eff)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [17:0] act,
                         input logic [17:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name,
                     $signed(act), $signed(expv), $time);
        end
    endtask

    always @(posedge clock) pend <= issued;

    always @(negedge clock) begin
        if (pend) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow got empty expected entry");
            end else begin
                mon_e = q.pop_front();
                check("spike", {17'd0, spike}, {17'd0, mon_e.spk});
                check("v_mem", v_mem, mon_e.v);
                check("refractory", {17'd0, refractory}, {17'd0, mon_e.refr});
                check("thr_eff", thr_eff, mon_e.thr);
            end
        end
    end

    task automatic do_cycle(input logic st, input logic [17:0] isyn,
                            input logic espk, input logic [17:0] ev,
                            input logic erefr);
        exp_t e;
        if (st) begin
            if (espk) th = (th + 64 > 4095) ? 4095 : th + 64;
            else if (th > 0) th = th - 1;
        end
        e.spk  = espk;
        e.v    = ev;
        e.refr = erefr;
`ifdef ADAPTIVE_THRESHOLD_EN
        e.thr  = 18'(1000 + th);
`else
        e.thr  = 18'd1000;
`endif
        q.push_back(e);
        step   = st;
        i_syn  = isyn;
        issued = 1'b1;
        @(posedge clock);
        #1;
        issued = 1'b0;
        step   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("rst_v_mem", v_mem, 18'd0);
        check("rst_spike", {17'd0, spike}, 18'd0);
        check("rst_refr", {17'd0, refractory}, 18'd0);
        check("rst_thr", thr_eff, 18'd1000);
        th = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        step  = 1'b0;
        i_syn = '0;
        do_reset();

        // Idle
        for (int i = 0; i < 20; i++) do_cycle(1'b1, 18'd0, 1'b0, 18'd0, 1'b0);

        // Integration to first spike
        do_reset();
        do_cycle(1'b1, 18'd200, 1'b0, 18'd200, 1'b0);
        do_cycle(1'b1, 18'd200, 1'b0, 18'd388, 1'b0);
        do_cycle(1'b1, 18'd200, 1'b0, 18'd564, 1'b0);
        do_cycle(1'b1, 18'd200, 1'b0, 18'd729, 1'b0);
        do_cycle(1'b1, 18'd200, 1'b0, 18'd884, 1'b0);
        do_cycle(1'b1, 18'd200, 1'b1, 18'd0, 1'b1);

        // Refractory period, spikes every 5 steps
        do_reset();
        for (int p = 0; p < 3; p++) begin
            do_cycle(1'b1, 18'd1500, 1'b1, 18'd0, 1'b1);
            do_cycle(1'b1, 18'd1500, 1'b0, 18'd0, 1'b1);
            do_cycle(1'b1, 18'd1500, 1'b0, 18'd0, 1'b1);
            do_cycle(1'b1, 18'd1500, 1'b0, 18'd0, 1'b1);
            do_cycle(1'b1, 18'd1500, 1'b0, 18'd0, 1'b0);
        end

        // Negative saturation, then hold with step low
        do_reset();
        do_cycle(1'b1, NEG_MAX, 1'b0, NEG_MAX, 1'b0);
        do_cycle(1'b1, NEG_MAX, 1'b0, NEG_MAX, 1'b0);
        do_cycle(1'b1, NEG_MAX, 1'b0, NEG_MAX, 1'b0);
        do_cycle(1'b0, 18'd5000, 1'b0, NEG_MAX, 1'b0);
        do_cycle(1'b0, 18'd5000, 1'b0, NEG_MAX, 1'b0);

        // Async reset mid-spike / mid-refractory
        do_reset();
        do_cycle(1'b1, 18'd1500, 1'b1, 18'd0, 1'b1);
        do_reset();
        do_cycle(1'b1, 18'd1500, 1'b1, 18'd0, 1'b1);
        do_cycle(1'b1, 18'd0, 1'b0, 18'd0, 1'b1);
        do_reset();
        do_cycle(1'b1, 18'd1500, 1'b1, 18'd0, 1'b1);

`ifdef ADAPTIVE_THRESHOLD_EN
        // Adaptive threshold rise and decay
        do_reset();
        do_cycle(1'b1, 18'd1500, 1'b1, 18'd0, 1'b1);
        check("thr_after_spike", thr_eff, 18'd1064);
        for (int i = 0; i < 3; i++)
            do_cycle(1'b1, 18'd1500, 1'b0, 18'd0, 1'b1);
        do_cycle(1'b1, 18'd1500, 1'b0, 18'd0, 1'b0);
        check("thr_after_refract", thr_eff, 18'd1060);
`endif

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain got %0d left expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
